// File: rtl/mmio_mailbox_target.sv
// MMIO mailbox target: 4-register window bridging a TX FIFO (bus -> stream)
// and an RX FIFO (stream -> bus) on the shared add/dat/rd/wrt processor bus.
module mmio_mailbox_target #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] add,
  inout  wire  [7:0] dat,
  input  logic       rd,
  input  logic       wrt,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       irq
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic       rd_q, wrt_q, hit_q, live_q;
  logic [7:0] rdata_q, err_q;
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  ptr_t       tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  cnt_t       tx_cnt_q, rx_cnt_q;

  logic       decoded, both_strobes;
  logic [1:0] off;
  logic       rd_fire, wrt_fire, collision, rd_acc, wr_acc;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push_req, tx_push, tx_pop;
  logic       rx_pop_req, rx_pop, rx_push;
  logic       flush_tx, flush_rx;
  logic [7:0] status, rdata_next, err_set, err_clr;

  assign decoded      = (add[7:2] == BASE_ADDR[7:2]);
  assign off          = add[1:0];
  assign both_strobes = rd & wrt;

  // live_q suppresses the first edge after reset release, so a strobe that
  // was already high when reset lifted never counts as a fresh rising edge.
  assign rd_fire   = live_q & rd & ~rd_q;
  assign wrt_fire  = live_q & wrt & ~wrt_q;
  assign collision = decoded & (rd_fire | wrt_fire) & both_strobes;
  assign rd_acc    = decoded & rd_fire & ~both_strobes;
  assign wr_acc    = decoded & wrt_fire & ~both_strobes;

  assign tx_full  = (tx_cnt_q == cnt_t'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == cnt_t'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_push_req = wr_acc & (off == 2'd0);
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = out_valid & out_ready;
  assign flush_tx    = wr_acc & (off == 2'd2) & dat[0];
  assign flush_rx    = wr_acc & (off == 2'd2) & dat[1];
  assign rx_pop_req  = rd_acc & (off == 2'd0);
  assign rx_pop      = rx_pop_req & ~rx_empty;
  assign rx_push     = in_valid & in_ready;

  assign err_set = {5'b0, collision, rx_pop_req & rx_empty, tx_push_req & tx_full};
  assign err_clr = (wr_acc && off == 2'd3) ? dat : 8'h00;
  assign status  = {4'b0, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rdata_next = 8'h00;
    case (off)
      2'd0:    if (!rx_empty) rdata_next = rx_mem[rx_rp_q];
      2'd1:    rdata_next = status;
      2'd3:    rdata_next = err_q;
      default: rdata_next = 8'h00;
    endcase
  end

  assign out_valid = ~tx_empty;
  assign out_data  = tx_mem[tx_rp_q];
  assign in_ready  = rst & ~rx_full;
  assign irq       = ~rx_empty | (|err_q);
  assign dat       = (rd & rd_q & hit_q) ? rdata_q : 8'hzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q   <= 1'b0;
      rd_q     <= 1'b0;
      wrt_q    <= 1'b0;
      hit_q    <= 1'b0;
      rdata_q  <= 8'h00;
      err_q    <= 8'h00;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      live_q <= 1'b1;
      rd_q   <= rd;
      wrt_q  <= wrt;
      if (!rd)
        hit_q <= 1'b0;
      else if (rd_acc)
        hit_q <= 1'b1;
      if (rd_acc)
        rdata_q <= rdata_next;
      // A new error in the same edge as its write-1-to-clear stays set.
      err_q <= (err_q & ~err_clr) | err_set;

      if (flush_tx) begin
        tx_wp_q  <= '0;
        tx_rp_q  <= '0;
        tx_cnt_q <= '0;
      end else begin
        if (tx_push) tx_wp_q <= tx_wp_q + ptr_t'(1);
        if (tx_pop)  tx_rp_q <= tx_rp_q + ptr_t'(1);
        case ({tx_push, tx_pop})
          2'b10:   tx_cnt_q <= tx_cnt_q + cnt_t'(1);
          2'b01:   tx_cnt_q <= tx_cnt_q - cnt_t'(1);
          default: tx_cnt_q <= tx_cnt_q;
        endcase
      end

      if (flush_rx) begin
        rx_wp_q  <= '0;
        rx_rp_q  <= '0;
        rx_cnt_q <= '0;
      end else begin
        if (rx_push) rx_wp_q <= rx_wp_q + ptr_t'(1);
        if (rx_pop)  rx_rp_q <= rx_rp_q + ptr_t'(1);
        case ({rx_push, rx_pop})
          2'b10:   rx_cnt_q <= rx_cnt_q + cnt_t'(1);
          2'b01:   rx_cnt_q <= rx_cnt_q - cnt_t'(1);
          default: rx_cnt_q <= rx_cnt_q;
        endcase
      end
    end
  end

  // Storage is not reset; the pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= dat;
    if (rx_push) rx_mem[rx_wp_q] <= in_data;
  end

endmodule

// File: tb/tb_mmio_mailbox_target.sv
// Self-checking bench for mmio_mailbox_target: directed scenarios plus a random
// phase, checked against a queue-based model of the register window and FIFOs.
module tb_mmio_mailbox_target;
  localparam int         DEPTH = 4;
  localparam logic [7:0] MARK  = 8'hC3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] add = 8'h00;
  logic       rd = 1'b0, wrt = 1'b0;
  logic       out_ready = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] out_data;
  logic       out_valid, in_ready, irq;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_dat = 8'h00;
  wire  [7:0] dat;

  assign dat = tb_oe ? tb_dat : 8'hzz;

  mmio_mailbox_target #(.BASE_ADDR(8'hF0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .add(add), .dat(dat), .rd(rd), .wrt(wrt),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] err_m = 8'h00;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {7'b0, obs}, {7'b0, exp});
  endtask

  function automatic logic [7:0] status_m();
    return {4'b0, rx_q.size() == 0, rx_q.size() == DEPTH, tx_q.size() == 0, tx_q.size() == DEPTH};
  endfunction

  task automatic check_irq(input string tag);
    @(negedge clk);
    check1(tag, irq, (rx_q.size() != 0) || (err_m != 8'h00));
  endtask

  // Release check: with the bench driving a marker, the bus must read back the marker.
  task automatic check_released(input string tag);
    tb_dat = MARK;
    tb_oe  = 1'b1;
    #1;
    check(tag, dat, MARK);
    tb_oe = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    add = a; tb_dat = d; tb_oe = 1'b1; wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0; tb_oe = 1'b0;
    if (a[7:2] == 6'h3C) begin
      case (a[1:0])
        2'd0: if (tx_q.size() == DEPTH) err_m |= 8'h01; else tx_q.push_back(d);
        2'd2: begin
          if (d[0]) tx_q.delete();
          if (d[1]) rx_q.delete();
        end
        2'd3: err_m &= ~d;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] a, input int hold, input string tag);
    logic [7:0] exp;
    logic       hit;
    hit = (a[7:2] == 6'h3C);
    exp = 8'h00;
    if (hit) begin
      case (a[1:0])
        2'd0: if (rx_q.size() == 0) err_m |= 8'h02; else exp = rx_q.pop_front();
        2'd1: exp = status_m();
        2'd3: exp = err_m;
        default: exp = 8'h00;
      endcase
    end
    @(negedge clk);
    add = a; rd = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (hit) check(tag, dat, exp);
      else check_released({tag, "_z"});
    end
    rd = 1'b0;
    check_released({tag, "_rel"});
    @(negedge clk);
  endtask

  task automatic stream_in(input logic [7:0] d);
    logic room;
    room = (rx_q.size() < DEPTH);
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    #1;
    check1("in_ready", in_ready, room);
    if (room) rx_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain_tx(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check1("out_valid", out_valid, tx_q.size() != 0);
      if (tx_q.size() != 0) begin
        check("out_data", out_data, tx_q[0]);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        b = tx_q.pop_front();
      end
    end
  endtask

  initial begin
    logic [7:0] exp;
    int         op;

    // 1: reset state
    repeat (2) @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_irq", irq, 1'b0);
    check_released("rst_dat_z");
    rst = 1'b1;
    @(negedge clk);
    check1("t1_in_ready", in_ready, 1'b1);
    check1("t1_out_valid", out_valid, 1'b0);
    bus_read(8'hF1, 2, "t1_status");

    // 2: TX fill, overflow, drain
    bus_write(8'hF0, 8'h11);
    bus_write(8'hF0, 8'h22);
    bus_write(8'hF0, 8'h33);
    bus_write(8'hF0, 8'h44);
    bus_write(8'hF0, 8'h55);
    bus_read(8'hF1, 2, "t2_status");
    bus_read(8'hF3, 2, "t2_err");
    drain_tx(5);
    bus_write(8'hF3, 8'h01);
    check_irq("t2_irq");

    // 3: RX stream in, pops, underflow, W1C
    stream_in(8'hA5);
    stream_in(8'h5A);
    check_irq("t3_irq_set");
    bus_read(8'hF0, 2, "t3_pop0");
    bus_read(8'hF0, 2, "t3_pop1");
    bus_read(8'hF0, 2, "t3_pop_empty");
    bus_read(8'hF3, 2, "t3_err");
    bus_write(8'hF3, 8'h02);
    check_irq("t3_irq_clr");
    bus_read(8'hF3, 2, "t3_err_clr");

    // 4: held read pops once; undecoded read leaves the bus alone
    stream_in(8'($urandom));
    stream_in(8'($urandom));
    bus_read(8'hF0, 5, "t4_held");
    bus_read(8'hF1, 2, "t4_status");
    bus_read(8'hE0, 3, "t4_undec");
    bus_read(8'hF0, 2, "t4_pop_rest");

    // 5: collision, then flush both FIFOs
    @(negedge clk);
    add = 8'hF0; tb_dat = MARK; tb_oe = 1'b1; rd = 1'b1; wrt = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 check("t5_coll_z", dat, MARK);
    end
    rd = 1'b0; wrt = 1'b0; tb_oe = 1'b0;
    err_m |= 8'h04;
    @(negedge clk);
    bus_read(8'hF3, 2, "t5_err");
    bus_read(8'hF1, 2, "t5_status");
    bus_write(8'hF3, 8'h04);
    for (int i = 0; i < 3; i++) begin
      bus_write(8'hF0, 8'($urandom));
      stream_in(8'($urandom));
    end
    bus_read(8'hF1, 2, "t5_status_full3");
    bus_write(8'hF2, 8'h03);
    check1("t5_flush_valid", out_valid, 1'b0);
    bus_read(8'hF1, 2, "t5_status_flushed");

    // random phase against the model
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: bus_write(8'hF0, 8'($urandom));
        1: stream_in(8'($urandom));
        2: bus_read(8'hF0, int'($urandom_range(2, 4)), "rnd_pop");
        3: drain_tx(1);
        default: bus_read($urandom_range(0, 1) != 0 ? 8'hF1 : 8'hF3, 2, "rnd_reg");
      endcase
      check_irq("rnd_irq");
    end
    bus_write(8'hF3, 8'hFF);
    bus_read(8'hF3, 2, "rnd_err_clr");

    // 6: reset in the middle of a driven read
    bus_write(8'hF2, 8'h03);
    bus_read(8'hF0, 2, "t6_underflow");
    stream_in(8'($urandom));
    stream_in(8'($urandom));
    bus_write(8'hF0, 8'($urandom));
    exp = rx_q[0];
    @(negedge clk);
    add = 8'hF0; rd = 1'b1;
    @(negedge clk);
    check("t6_driven", dat, exp);
    #2 rst = 1'b0;
    check_released("t6_rst_z");
    check1("t6_rst_valid", out_valid, 1'b0);
    check1("t6_rst_ready", in_ready, 1'b0);
    check1("t6_rst_irq", irq, 1'b0);
    tx_q.delete();
    rx_q.delete();
    err_m = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_released("t6_held_z");
    end
    rd = 1'b0;
    @(negedge clk);
    bus_read(8'hF1, 2, "t6_status");
    bus_read(8'hF3, 2, "t6_err");
    check1("t6_out_valid", out_valid, 1'b0);
    bus_read(8'hF0, 2, "t6_refire");
    bus_read(8'hF3, 2, "t6_err_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
